// File: rtl/led_pwm_decoder_pkg.sv
// Shared definitions for the LED breathing-PWM link: frame length, FSM states, clog2.
package led_pwm_decoder_pkg;

  localparam int unsigned LED_FRAME_LEN = 16;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/led_pwm_decoder_bus_sync.sv
// Multi-stage flop synchronizer for the asynchronous 8-bit LED bus.
module led_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_async,
  output logic [7:0] bus_sync
);

  logic [7:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= bus_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign bus_sync = stage[SYNC_STAGES-1];

endmodule

// File: rtl/led_pwm_decoder.sv
// Receive side of the LED PWM link: recovers per-frame brightness level and lit-LED index.
module led_pwm_decoder
  import led_pwm_decoder_pkg::*;
#(
  parameter  int unsigned FRAME_LEN   = LED_FRAME_LEN,
  parameter  int unsigned SLOT_CYCLES = 1,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned LW          = clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    led_bus,
  output logic [LW-1:0] level,
  output logic [2:0]    led_index,
  output logic          level_valid,
  output logic          locked,
  output logic          sync_err,
  output logic          onehot_err,
  output logic          stuck_high
);

  localparam int unsigned DW       = (SLOT_CYCLES > 1) ? clog2(SLOT_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SLOT_CYCLES - 1);
  localparam logic [LW-1:0] F_LAST   = LW'(FRAME_LEN - 1);
  localparam logic [LW:0]   FULL     = (LW+1)'(FRAME_LEN);

  logic [7:0]    bus_s;
  logic          pwm, pwm_d, prev;
  logic [DW-1:0] div_cnt, div_eff;
  logic          strobe;
  state_t        state, state_nxt;
  logic [LW-1:0] frame_cnt;
  logic [LW:0]   hi_cnt, hi_sum, run_cnt, run_nxt;
  logic [2:0]    idx, idx_nxt, idx_sel;
  logic          multi, single, rise;
  logic          phase_jump, all_high, frame_end, run_low_full, run_high_full;

  led_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_async (led_bus),
    .bus_sync  (bus_s)
  );

  assign pwm = |bus_s;

  // While hunting, a line change starts a new slot so strobes land at slot ends.
  assign div_eff = (state == ST_HUNT && (pwm ^ pwm_d)) ? '0 : div_cnt;
  assign strobe  = (div_eff == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pwm_d   <= 1'b0;
    end else begin
      div_cnt <= strobe ? '0 : div_eff + DW'(1);
      pwm_d   <= pwm;
    end
  end

  assign multi   = (bus_s & (bus_s - 8'd1)) != 8'd0;
  assign single  = pwm && !multi;
  assign rise    = pwm && !prev;
  assign hi_sum  = hi_cnt + (LW+1)'(pwm);
  assign run_nxt = (pwm == prev) ? run_cnt + (LW+1)'(1) : (LW+1)'(1);

  always_comb begin
    idx_nxt = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (bus_s[i]) idx_nxt = 3'(i);
  end

  assign idx_sel = single ? idx_nxt : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (strobe) begin
      case (state)
        ST_HUNT:    if (rise) state_nxt = ST_MEASURE;
        ST_MEASURE: if (!(rise && frame_cnt != '0) && hi_sum == FULL) state_nxt = ST_HUNT;
        default:    state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    phase_jump    = 1'b0;
    all_high      = 1'b0;
    frame_end     = 1'b0;
    run_low_full  = 1'b0;
    run_high_full = 1'b0;
    locked        = (state == ST_MEASURE);
    if (strobe) begin
      case (state)
        ST_HUNT: begin
          if (!rise && run_nxt == FULL) begin
            run_high_full = pwm;
            run_low_full  = !pwm;
          end
        end
        ST_MEASURE: begin
          if (rise && frame_cnt != '0) phase_jump = 1'b1;
          else if (hi_sum == FULL)     all_high   = 1'b1;
          else if (frame_cnt == F_LAST) frame_end = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= 1'b0;
      frame_cnt   <= '0;
      hi_cnt      <= '0;
      run_cnt     <= '0;
      idx         <= '0;
      level       <= '0;
      led_index   <= '0;
      level_valid <= 1'b0;
      sync_err    <= 1'b0;
      onehot_err  <= 1'b0;
      stuck_high  <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      sync_err    <= 1'b0;
      onehot_err  <= 1'b0;
      if (strobe) begin
        prev       <= pwm;
        onehot_err <= multi;
        if (single) idx <= idx_nxt;
        if (!pwm) stuck_high <= 1'b0;
        if (run_high_full || all_high) stuck_high <= 1'b1;

        if (state == ST_HUNT && !rise && !run_low_full && !run_high_full) run_cnt <= run_nxt;
        else                                                            run_cnt <= '0;

        if (state == ST_HUNT) begin
          if (rise) begin
            frame_cnt <= LW'(1);
            hi_cnt    <= (LW+1)'(1);
          end
          if (run_low_full) begin
            level       <= '0;
            led_index   <= idx_sel;
            level_valid <= 1'b1;
          end
        end else if (phase_jump) begin
          frame_cnt <= LW'(1);
          hi_cnt    <= (LW+1)'(1);
          sync_err  <= 1'b1;
        end else if (all_high) begin
          frame_cnt <= '0;
          hi_cnt    <= '0;
        end else if (frame_end) begin
          frame_cnt   <= '0;
          hi_cnt      <= '0;
          level       <= hi_sum[LW-1:0];
          led_index   <= idx_sel;
          level_valid <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + LW'(1);
          hi_cnt    <= hi_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_decoder.sv
// Scoreboard bench for led_pwm_decoder: slot-level reference model feeds an event queue.
module tb_led_pwm_decoder;

  localparam int FL = 16;
  localparam int SC = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led_bus = '0;
  logic [3:0] level;
  logic [2:0] led_index;
  logic       level_valid, locked, sync_err, onehot_err, stuck_high;

  always #5 clk = ~clk;

  led_pwm_decoder #(.FRAME_LEN(FL), .SLOT_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .led_bus     (led_bus),
    .level       (level),
    .led_index   (led_index),
    .level_valid (level_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .onehot_err  (onehot_err),
    .stuck_high  (stuck_high)
  );

  typedef struct {
    bit valid;
    int lvl;
    int idx;
    bit serr;
    bit oerr;
    bit lk;
    bit st;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model state, one update per slot
  int m_meas, m_prev, m_f, m_hi, m_run, m_idx, m_stuck, m_lk_last, m_st_last;

  task automatic model_reset();
    m_meas = 0; m_prev = 0; m_f = 0; m_hi = 0; m_run = 0;
    m_idx = 0; m_stuck = 0; m_lk_last = 0; m_st_last = 0;
  endtask

  task automatic model_sample(input logic [7:0] b);
    int  s, nb, h;
    ev_t e;
    s = (b != 8'd0) ? 1 : 0;
    nb = $countones(b);
    e.valid = 0; e.lvl = 0; e.idx = 0; e.serr = 0;
    e.oerr = (s == 1 && nb > 1);
    if (s == 1 && nb == 1)
      for (int i = 0; i < 8; i++) if (b[i]) m_idx = i;
    if (s == 0) m_stuck = 0;
    if (m_meas == 0) begin
      if (s == 1 && m_prev == 0) begin
        m_meas = 1; m_f = 1; m_hi = 1; m_run = 0;
      end else begin
        m_run = (s == m_prev) ? m_run + 1 : 1;
        if (m_run == FL) begin
          m_run = 0;
          if (s == 1) m_stuck = 1;
          else begin e.valid = 1; e.lvl = 0; e.idx = m_idx; end
        end
      end
    end else begin
      if (s == 1 && m_prev == 0 && m_f != 0) begin
        e.serr = 1; m_f = 1; m_hi = 1;
      end else begin
        h = m_hi + s;
        if (h == FL) begin
          m_stuck = 1; m_meas = 0; m_f = 0; m_hi = 0; m_run = 0;
        end else if (m_f == FL - 1) begin
          e.valid = 1; e.lvl = h; e.idx = m_idx; m_f = 0; m_hi = 0;
        end else begin
          m_hi = h; m_f = m_f + 1;
        end
      end
    end
    m_prev = s;
    e.lk = (m_meas != 0);
    e.st = (m_stuck != 0);
    if (e.valid || e.serr || e.oerr || m_meas != m_lk_last || m_stuck != m_st_last)
      exp_q.push_back(e);
    m_lk_last = m_meas;
    m_st_last = m_stuck;
  endtask

  task automatic issue(input logic [7:0] b);
    led_bus = b;
    model_sample(b);
    repeat (SC) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int lvl, input logic [7:0] b);
    for (int k = 0; k < FL; k++) issue((k < lvl) ? b : 8'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({level, led_index, level_valid, locked, sync_err, onehot_err, stuck_high} != '0) begin
      failures++;
      $display("FAIL %s: outputs during reset level=%0d idx=%0d v=%0b lk=%0b se=%0b oe=%0b st=%0b, required all 0",
               tag, level, led_index, level_valid, locked, sync_err, onehot_err, stuck_high);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    led_bus = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Monitor: every observable event from the DUT consumes one expected entry
  initial begin
    ev_t      e;
    bit [1:0] last;
    bit       ok;
    int       n;
    last = '0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = '0;
        continue;
      end
      if (level_valid || sync_err || onehot_err || {locked, stuck_high} != last) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL event#%0d: unexpected v=%0b level=%0d idx=%0d se=%0b oe=%0b lk=%0b st=%0b, required no event",
                   n, level_valid, level, led_index, sync_err, onehot_err, locked, stuck_high);
        end else begin
          e = exp_q.pop_front();
          ok = (e.valid == level_valid) && (e.serr == sync_err) && (e.oerr == onehot_err) &&
               (e.lk == locked) && (e.st == stuck_high) &&
               (!e.valid || (int'(level) == e.lvl && int'(led_index) == e.idx));
          if (!ok) begin
            failures++;
            $display("FAIL event#%0d: got v=%0b level=%0d idx=%0d se=%0b oe=%0b lk=%0b st=%0b, required v=%0b level=%0d idx=%0d se=%0b oe=%0b lk=%0b st=%0b",
                     n, level_valid, level, led_index, sync_err, onehot_err, locked, stuck_high,
                     e.valid, e.lvl, e.idx, e.serr, e.oerr, e.lk, e.st);
          end
        end
        last = {locked, stuck_high};
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, lvl, cut, t;
    logic [7:0] b;
    model_reset();
    do_reset("initial_reset");

    repeat (40) issue(8'h00);
    repeat (3) frame(5, 8'h04);

    repeat (2) frame(7, 8'h10);
    for (int k = 0; k < 9; k++) issue((k < 7) ? 8'h10 : 8'h00);
    repeat (2) frame(7, 8'h10);

    frame(3, 8'h06);
    frame(4, 8'h02);

    repeat (16) issue(8'h80);
    repeat (3) issue(8'h00);

    frame(10, 8'h08);
    for (int k = 0; k < 8; k++) issue(8'h08);
    do_reset("mid_frame_reset");
    repeat (2) frame(10, 8'h08);

    for (int j = 0; j < 80; j++) begin
      r   = $urandom_range(0, 9);
      lvl = $urandom_range(0, FL - 1);
      b   = 8'h01 << $urandom_range(0, 7);
      case (r)
        6: frame(lvl, b | (8'h01 << $urandom_range(0, 7)));
        7: begin
          cut = $urandom_range(1, FL - 1);
          for (int k = 0; k < cut; k++) issue((k < lvl) ? b : 8'h00);
        end
        8: repeat ($urandom_range(10, 20)) issue(b);
        9: repeat ($urandom_range(10, 20)) issue(8'h00);
        default: frame(lvl, b);
      endcase
    end

    // Finish on quiet low samples so trailing unmodelled strobes produce no event
    repeat (2) issue(8'h00);
    for (int k = 0; k < 40; k++) begin
      if (m_stuck == 0 && ((m_meas == 1 && m_f >= 1 && m_f <= 9) ||
                           (m_meas == 0 && m_prev == 0 && m_run <= 9))) break;
      issue(8'h00);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 64) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected events never observed, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
